// File: rtl/bcd_counter_ndigit_pkg.sv
// bcd_pkg: shared BCD limits and nibble helpers for the N-digit counter
package bcd_pkg;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;
    function automatic logic [3:0] bcd_clamp(input logic [3:0] n);
        return n > BCD_MAX ? BCD_MAX : n;
    endfunction
    function automatic logic is_bcd(input logic [3:0] n);
        return n <= BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd_counter_ndigit_if.sv
// bcd_counter_ndigit_if: control and status bundle of the N-digit BCD counter
interface bcd_counter_ndigit_if #(parameter int DIGITS = 4) ();
    logic                  cnt_en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   q;
    logic                  tc_out;
    logic                  zero;
    logic                  load_err;
    modport master (output cnt_en, up, load, load_val, input q, tc_out, zero, load_err);
    modport slave (input cnt_en, up, load, load_val, output q, tc_out, zero, load_err);
endinterface

// File: rtl/bcd_counter_ndigit_cell.sv
// bcd_digit_cell: one BCD digit with load, step and terminal detect
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       up,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       hold,
    output logic [3:0] d,
    output logic       term
);
    assign term = up ? d == BCD_MAX : d == BCD_MIN;
    always_ff @(posedge clk)
        if (rst) d <= BCD_MIN;
        else if (ld) d <= bcd_clamp(ld_val);
        else if (step && !hold) d <= up ? (d == BCD_MAX ? BCD_MIN : d + 4'd1) : (d == BCD_MIN ? BCD_MAX : d - 4'd1);
endmodule

// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: cascadable N-digit BCD up/down counter with load, wrap/saturate and flags
module bcd_counter_ndigit
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input logic clk,
    input logic rst,
    bcd_counter_ndigit_if.slave bus
);
    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] step;
    logic              all_term;
    logic              hold;
    logic              bad;
    assign all_term = &term;
    // saturating mode freezes every digit when the whole counter sits at its terminal value
    assign hold = !WRAP && all_term && bus.cnt_en;
    assign bus.tc_out = !rst && bus.cnt_en && all_term;
    assign bus.zero = bus.q == '0;
    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_dig
            if (i == 0) begin : g_lsd
                assign step[i] = bus.cnt_en;
            end else begin : g_msd
                assign step[i] = step[i-1] && term[i-1];
            end
            bcd_digit_cell u_cell (
                .clk    (clk),
                .rst    (rst),
                .step   (step[i]),
                .up     (bus.up),
                .ld     (bus.load),
                .ld_val (bus.load_val[4*i +: 4]),
                .hold   (hold),
                .d      (bus.q[4*i +: 4]),
                .term   (term[i])
            );
        end
    endgenerate
    always_comb begin
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) bad = bad || !is_bcd(bus.load_val[4*k +: 4]);
    end
    always_ff @(posedge clk)
        if (rst) bus.load_err <= 1'b0;
        else bus.load_err <= bus.load && bad;
endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// tb_bcd_counter_ndigit: directed and cascade-scoreboard checks of the N-digit BCD counter
module tb_bcd_counter_ndigit;
    logic clk;
    logic rst;
    int   tests;
    int   failed;
    bcd_counter_ndigit_if #(.DIGITS(4)) bus ();
    bcd_counter_ndigit_if #(.DIGITS(4)) sbus ();
    bcd_counter_ndigit_if #(.DIGITS(2)) lbus ();
    bcd_counter_ndigit_if #(.DIGITS(2)) hbus ();
    bcd_counter_ndigit #(.DIGITS(4), .WRAP(1)) dut     (.clk(clk), .rst(rst), .bus(bus));
    bcd_counter_ndigit #(.DIGITS(4), .WRAP(0)) dut_sat (.clk(clk), .rst(rst), .bus(sbus));
    bcd_counter_ndigit #(.DIGITS(2), .WRAP(1)) dut_lo  (.clk(clk), .rst(rst), .bus(lbus));
    bcd_counter_ndigit #(.DIGITS(2), .WRAP(1)) dut_hi  (.clk(clk), .rst(rst), .bus(hbus));
    assign hbus.cnt_en = lbus.tc_out;
    assign hbus.up = lbus.up;
    assign hbus.load = lbus.load;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction
    task automatic test_reset();
        rst = 1'b1;
        bus.cnt_en = 1'b1; bus.up = 1'b1;
        sbus.cnt_en = 1'b1; sbus.up = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (bus.q !== 16'h0000 || bus.load_err !== 1'b0 || bus.tc_out !== 1'b0) begin
                failed++;
                $display("FAIL reset: q=%h load_err=%b tc_out=%b, want 0000/0/0", bus.q, bus.load_err, bus.tc_out);
            end
            tests++;
            if (sbus.tc_out !== 1'b0) begin
                failed++;
                $display("FAIL reset_tc_forced: tc_out=%b, want 0", sbus.tc_out);
            end
        end
        sbus.cnt_en = 1'b0;
        rst = 1'b0;
        tick();
        bus.cnt_en = 1'b0;
        tests++;
        if (bus.q !== 16'h0001) begin
            failed++;
            $display("FAIL reset_release: q=%h, want 0001", bus.q);
        end
    endtask
    task automatic test_carry();
        bus.load = 1'b1; bus.load_val = 16'h0199;
        tick();
        bus.load = 1'b0; bus.cnt_en = 1'b1; bus.up = 1'b1;
        tick();
        tests++;
        if (bus.q !== 16'h0200) begin
            failed++;
            $display("FAIL carry_ripple: q=%h, want 0200", bus.q);
        end
        repeat (800) tick();
        bus.cnt_en = 1'b0;
        tests++;
        if (bus.q !== 16'h1000) begin
            failed++;
            $display("FAIL carry_800: q=%h, want 1000", bus.q);
        end
    endtask
    task automatic test_wrap();
        bus.load = 1'b1; bus.load_val = 16'h9999;
        tick();
        bus.load = 1'b0; bus.cnt_en = 1'b1; bus.up = 1'b1;
        #1;
        tests++;
        if (bus.tc_out !== 1'b1) begin
            failed++;
            $display("FAIL wrap_up_tc: tc_out=%b, want 1", bus.tc_out);
        end
        tick();
        tests++;
        if (bus.q !== 16'h0000 || bus.zero !== 1'b1) begin
            failed++;
            $display("FAIL wrap_up: q=%h zero=%b, want 0000/1", bus.q, bus.zero);
        end
        bus.up = 1'b0;
        #1;
        tests++;
        if (bus.tc_out !== 1'b1) begin
            failed++;
            $display("FAIL wrap_down_tc: tc_out=%b, want 1", bus.tc_out);
        end
        tick();
        bus.cnt_en = 1'b0;
        tests++;
        if (bus.q !== 16'h9999 || bus.zero !== 1'b0) begin
            failed++;
            $display("FAIL wrap_down: q=%h zero=%b, want 9999/0", bus.q, bus.zero);
        end
    endtask
    task automatic test_saturate();
        sbus.load = 1'b1; sbus.load_val = 16'h9999;
        tick();
        sbus.load = 1'b0; sbus.cnt_en = 1'b1; sbus.up = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++;
            if (sbus.q !== 16'h9999 || sbus.tc_out !== 1'b1) begin
                failed++;
                $display("FAIL saturate_hold: q=%h tc_out=%b, want 9999/1", sbus.q, sbus.tc_out);
            end
        end
        sbus.up = 1'b0;
        tick();
        sbus.cnt_en = 1'b0;
        tests++;
        if (sbus.q !== 16'h9998) begin
            failed++;
            $display("FAIL saturate_down: q=%h, want 9998", sbus.q);
        end
    endtask
    task automatic test_load_err();
        bus.load = 1'b1; bus.load_val = 16'h3A7F; bus.cnt_en = 1'b1; bus.up = 1'b1;
        tick();
        bus.load = 1'b0; bus.cnt_en = 1'b0;
        tests++;
        if (bus.q !== 16'h3979 || bus.load_err !== 1'b1) begin
            failed++;
            $display("FAIL load_clamp: q=%h load_err=%b, want 3979/1", bus.q, bus.load_err);
        end
        tick();
        tests++;
        if (bus.q !== 16'h3979 || bus.load_err !== 1'b0) begin
            failed++;
            $display("FAIL load_err_pulse: q=%h load_err=%b, want 3979/0", bus.q, bus.load_err);
        end
        bus.load = 1'b1; bus.load_val = 16'h0042;
        tick();
        bus.load = 1'b0;
        tests++;
        if (bus.q !== 16'h0042 || bus.load_err !== 1'b0) begin
            failed++;
            $display("FAIL load_legal: q=%h load_err=%b, want 0042/0", bus.q, bus.load_err);
        end
    endtask
    task automatic test_rst_priority();
        rst = 1'b1; bus.load = 1'b1; bus.load_val = 16'h5555; bus.cnt_en = 1'b1;
        tick();
        rst = 1'b0; bus.load = 1'b0; bus.cnt_en = 1'b0;
        tests++;
        if (bus.q !== 16'h0000 || bus.load_err !== 1'b0) begin
            failed++;
            $display("FAIL rst_priority: q=%h load_err=%b, want 0000/0", bus.q, bus.load_err);
        end
    endtask
    task automatic test_cascade();
        int v;
        int nv;
        int shown;
        logic en;
        logic dir;
        logic ld;
        lbus.load = 1'b1; lbus.load_val = 8'h99; hbus.load_val = 8'h00; lbus.up = 1'b1; lbus.cnt_en = 1'b0;
        tick();
        lbus.load = 1'b0; lbus.cnt_en = 1'b1;
        tick();
        tests++;
        if ({hbus.q, lbus.q} !== 16'h0100) begin
            failed++;
            $display("FAIL cascade_carry: q=%h, want 0100", {hbus.q, lbus.q});
        end
        v = 100;
        shown = 0;
        for (int c = 0; c < 10000; c++) begin
            ld = $urandom_range(0, 9) == 0;
            en = $urandom_range(0, 3) != 0;
            dir = 1'($urandom_range(0, 1));
            nv = $urandom_range(0, 9999);
            lbus.load = ld; lbus.cnt_en = en; lbus.up = dir;
            {hbus.load_val, lbus.load_val} = to_bcd(nv);
            tick();
            if (ld) v = nv;
            else if (en) v = dir ? (v + 1) % 10000 : (v + 9999) % 10000;
            tests++;
            if ({hbus.q, lbus.q} !== to_bcd(v)) begin
                failed++;
                if (shown < 10) $display("FAIL cascade_model cycle %0d: q=%h, want %h", c, {hbus.q, lbus.q}, to_bcd(v));
                shown++;
            end
        end
        lbus.load = 1'b0; lbus.cnt_en = 1'b0;
    endtask
    initial begin
        tests = 0; failed = 0;
        rst = 1'b1;
        bus.cnt_en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.load_val = '0;
        sbus.cnt_en = 1'b0; sbus.up = 1'b1; sbus.load = 1'b0; sbus.load_val = '0;
        lbus.cnt_en = 1'b0; lbus.up = 1'b1; lbus.load = 1'b0; lbus.load_val = '0;
        hbus.load_val = '0;
        test_reset();
        test_carry();
        test_wrap();
        test_saturate();
        test_load_err();
        test_rst_priority();
        test_cascade();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
